// File: rtl/wb_openram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_openram_arbiter
//
// Purpose:
//   Lets two Wishbone slave ports share the single read/write port (port 0) of
//   an OpenRAM SRAM macro. Each Wishbone port decodes its own address window.
//   Only one transfer is in flight at a time, and a last-grant bit provides
//   round-robin fairness. Every transfer takes the same fixed sequence of
//   states:
//     IDLE  -> pick a winner and register the RAM inputs
//     SETUP -> chip select is active and the RAM samples at the end of the cycle
//     WAIT  -> chip select is released and read data is captured at the end
//     ACK   -> a single-cycle ack goes to the winner, unless it aborted
//   A request seen in IDLE cycle c is acked in cycle c+3.
//
// Optional feature (macro WB_OPENRAM_ARB_LOCK_EN):
//   When the macro is defined and the owner still holds cyc after its ACK, the
//   owner keeps the RAM for its whole Wishbone cycle. grant_o shows the owner
//   during idle gaps, and the other port waits until the owner drops cyc.
//   When the macro is undefined, arbitration is re-run for every transfer and
//   grant_o is 00 in IDLE.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock and synchronous active-high reset
//   wbs0_* / wbs1_*        Wishbone slave ports (stb, cyc, we, sel, dat, adr,
//                          ack, dat_o)
//   ram_clk0               RAM clock, equal to wb_clk_i
//   ram_csb0, ram_web0     active-low chip select and write enable
//   ram_wmask0             byte write mask (sel on writes, 0 on reads)
//   ram_addr0              RAM word address
//   ram_din0, ram_dout0    RAM write data and read data
//   grant_o                one-hot current owner (debug); 00 when idle
// -----------------------------------------------------------------------------
module wb_openram_arbiter #(
  parameter logic [31:0] WB0_BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] WB1_BASE_ADDR = 32'h3000_0000,
  parameter int unsigned ADDR_WIDTH    = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  wbs0_stb_i,
  input  logic                  wbs0_cyc_i,
  input  logic                  wbs0_we_i,
  input  logic [3:0]            wbs0_sel_i,
  input  logic [31:0]           wbs0_dat_i,
  input  logic [31:0]           wbs0_adr_i,
  output logic                  wbs0_ack_o,
  output logic [31:0]           wbs0_dat_o,

  input  logic                  wbs1_stb_i,
  input  logic                  wbs1_cyc_i,
  input  logic                  wbs1_we_i,
  input  logic [3:0]            wbs1_sel_i,
  input  logic [31:0]           wbs1_dat_i,
  input  logic [31:0]           wbs1_adr_i,
  output logic                  wbs1_ack_o,
  output logic [31:0]           wbs1_dat_o,

  output logic                  ram_clk0,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [3:0]            ram_wmask0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [31:0]           ram_din0,
  input  logic [31:0]           ram_dout0,

  output logic [1:0]            grant_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  // A window spans 4*2^ADDR_WIDTH bytes. Everything above that span must
  // match the base address.
  localparam int unsigned WIN_SHIFT = ADDR_WIDTH + 2;

  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base);
    in_window = (adr >> WIN_SHIFT) == (base >> WIN_SHIFT);
  endfunction

  // Registered state
  logic [1:0]            state_q,      state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q,      owner_d;
  logic                  xfer_we_q,    xfer_we_d;
  logic                  abort_q,      abort_d;
  logic                  csb_q,        csb_d;
  logic                  web_q,        web_d;
  logic [3:0]            wmask_q,      wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [31:0]           din_q,        din_d;
  logic                  ack0_q,       ack0_d;
  logic                  ack1_q,       ack1_d;
  logic [31:0]           dat0_q,       dat0_d;
  logic [31:0]           dat1_q,       dat1_d;
  logic [1:0]            grant_q,      grant_d;
`ifdef WB_OPENRAM_ARB_LOCK_EN
  logic                  lock_q,       lock_d;
`endif

  // Request decode and winner selection
  logic        req0, req1;
  logic        own_cyc;
  logic        locked;
  logic        win_vld;
  logic        win_port;
  logic        win_we;
  logic [3:0]  win_sel;
  logic [31:0] win_dat;
  logic [31:0] win_adr;

  assign req0    = wbs0_cyc_i & wbs0_stb_i & in_window(wbs0_adr_i, WB0_BASE_ADDR);
  assign req1    = wbs1_cyc_i & wbs1_stb_i & in_window(wbs1_adr_i, WB1_BASE_ADDR);
  assign own_cyc = owner_q ? wbs1_cyc_i : wbs0_cyc_i;

`ifdef WB_OPENRAM_ARB_LOCK_EN
  // The lock stays in force only while the owner still holds cyc.
  assign locked = lock_q & own_cyc;
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    win_vld  = 1'b0;
    win_port = 1'b0;
    if (locked) begin
      win_vld  = owner_q ? req1 : req0;
      win_port = owner_q;
    end else if (req0 && req1) begin
      // On a tie, the port that was not granted last time wins.
      win_vld  = 1'b1;
      win_port = ~last_grant_q;
    end else if (req0) begin
      win_vld  = 1'b1;
      win_port = 1'b0;
    end else if (req1) begin
      win_vld  = 1'b1;
      win_port = 1'b1;
    end
  end

  assign win_we  = win_port ? wbs1_we_i  : wbs0_we_i;
  assign win_sel = win_port ? wbs1_sel_i : wbs0_sel_i;
  assign win_dat = win_port ? wbs1_dat_i : wbs0_dat_i;
  assign win_adr = win_port ? wbs1_adr_i : wbs0_adr_i;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    xfer_we_d    = xfer_we_q;
    abort_d      = abort_q;
    csb_d        = csb_q;
    web_d        = web_q;
    wmask_d      = wmask_q;
    addr_d       = addr_q;
    din_d        = din_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    dat0_d       = dat0_q;
    dat1_d       = dat1_q;
    grant_d      = grant_q;
`ifdef WB_OPENRAM_ARB_LOCK_EN
    lock_d       = lock_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef WB_OPENRAM_ARB_LOCK_EN
        // The owner ended its Wishbone cycle, so release the lock and
        // return to normal arbitration.
        if (lock_q && !own_cyc) begin
          lock_d  = 1'b0;
          grant_d = 2'b00;
        end
`endif
        if (win_vld) begin
          state_d      = S_SETUP;
          owner_d      = win_port;
          last_grant_d = win_port;
          xfer_we_d    = win_we;
          abort_d      = 1'b0;
          csb_d        = 1'b0;
          web_d        = ~win_we;
          wmask_d      = win_we ? win_sel : 4'b0000;
          addr_d       = win_adr[ADDR_WIDTH+1:2];
          din_d        = win_dat;
          grant_d      = win_port ? 2'b10 : 2'b01;
`ifdef WB_OPENRAM_ARB_LOCK_EN
          lock_d       = 1'b0;
`endif
        end
      end

      S_SETUP: begin
        // The RAM samples at the end of this cycle; only deselect it afterwards.
        csb_d   = 1'b1;
        web_d   = 1'b1;
        if (!own_cyc) abort_d = 1'b1;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // The read completes in the RAM even if the master aborted, so
        // dat_o is still updated. Only the ack is withheld.
        if (!xfer_we_q) begin
          if (owner_q) dat1_d = ram_dout0;
          else         dat0_d = ram_dout0;
        end
        if (!abort_q && own_cyc) begin
          if (owner_q) ack1_d = 1'b1;
          else         ack0_d = 1'b1;
        end
        state_d = S_ACK;
      end

      S_ACK: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = S_IDLE;
`ifdef WB_OPENRAM_ARB_LOCK_EN
        if (own_cyc) lock_d  = 1'b1;
        else         grant_d = 2'b00;
`else
        grant_d = 2'b00;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Register stage: everything updates on the clock edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      xfer_we_q    <= 1'b0;
      abort_q      <= 1'b0;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      wmask_q      <= 4'b0000;
      addr_q       <= '0;
      din_q        <= 32'h0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      dat0_q       <= 32'h0;
      dat1_q       <= 32'h0;
      grant_q      <= 2'b00;
`ifdef WB_OPENRAM_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      xfer_we_q    <= xfer_we_d;
      abort_q      <= abort_d;
      csb_q        <= csb_d;
      web_q        <= web_d;
      wmask_q      <= wmask_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      dat0_q       <= dat0_d;
      dat1_q       <= dat1_d;
      grant_q      <= grant_d;
`ifdef WB_OPENRAM_ARB_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign ram_clk0   = wb_clk_i;
  assign ram_csb0   = csb_q;
  assign ram_web0   = web_q;
  assign ram_wmask0 = wmask_q;
  assign ram_addr0  = addr_q;
  assign ram_din0   = din_q;
  assign wbs0_ack_o = ack0_q;
  assign wbs1_ack_o = ack1_q;
  assign wbs0_dat_o = dat0_q;
  assign wbs1_dat_o = dat1_q;
  assign grant_o    = grant_q;

endmodule
